// File: rtl/dff_sched_pkg.sv
// rtl/dff_sched_pkg.sv - shared state type and default sizes for the DFF array write scheduler
// Contents: state_t (INIT, RUN) and the default NUM_REQ / DEPTH / WIDTH values.
package dff_sched_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DEPTH   = 16;
  localparam int DEF_WIDTH   = 32;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/dff_xchecker.sv
// rtl/dff_xchecker.sv - flags unknown write data whenever the write enable is high
// Ports:
//   clk   sampling clock
//   en    write enable
//   data  [WIDTH-1:0] write data that must be fully known while en is high
module dff_xchecker #(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             en,
  input logic [WIDTH-1:0] data
);

  a_no_x_wdata: assert property (@(posedge clk) en |-> !$isunknown(data));

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, lowest request at or above the pointer
// Ports:
//   req   [N-1:0]  request vector
//   ptr   [PW-1:0] index with highest priority this cycle
//   grant [N-1:0]  one-hot grant, all-zero when req is all-zero
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [N-1:0] mask;
  logic [N-1:0] masked;
  logic [N-1:0] src;

  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (i >= int'(ptr));
    end
    masked = req & mask;
    // Requests at or above the pointer win; otherwise wrap to the bottom.
    src   = (|masked) ? masked : req;
    // Isolate the lowest set bit.
    grant = src & (~src + N'(1));
  end

endmodule

// File: rtl/dff_array_wr_sched.sv
// rtl/dff_array_wr_sched.sv - zero-fills a DFF array after reset, then schedules round-robin writes
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   req_valid [NUM_REQ]      per-requester write request
//   req_addr  [NUM_REQ*AW]   per-requester address, slice i = requester i
//   req_data  [NUM_REQ*WIDTH] per-requester data, slice i = requester i
//   req_ready [NUM_REQ]      one-hot grant (combinational)
//   wr_stall                 storage busy, blocks all grants
//   WEN, WADDR, WDATA        registered write port to the array
//   init_done                high once every entry has been zeroed
module dff_array_wr_sched
  import dff_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*AW-1:0]    req_addr,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     wr_stall,
  output logic                     WEN,
  output logic [AW-1:0]            WADDR,
  output logic [WIDTH-1:0]         WDATA,
  output logic                     init_done
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t            state;
  state_t            state_next;
  logic [AW-1:0]     init_addr;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     gidx;
  logic [PW-1:0]     ptr_next;
  logic [NUM_REQ-1:0] grant;
  logic              grant_en;
  logic              xfer;

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= INIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant_en   = 1'b0;
    case (state)
      INIT: if (init_addr == AW'(DEPTH - 1)) state_next = RUN;
      RUN:  grant_en = !wr_stall;
      default: state_next = INIT;
    endcase
  end

  // Reset gates the grant combinationally so nothing transfers while RST is high.
  assign req_ready = (grant_en && !RST) ? grant : '0;
  assign xfer      = |req_ready;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gidx = PW'(i);
    end
    ptr_next = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + PW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      init_addr <= '0;
      rr_ptr    <= '0;
      WEN       <= 1'b0;
      WADDR     <= '0;
      WDATA     <= '0;
      init_done <= 1'b0;
    end else if (state == INIT) begin
      WEN       <= 1'b1;
      WADDR     <= init_addr;
      WDATA     <= '0;
      init_addr <= init_addr + AW'(1);
      // Raised with the last sweep write so it coincides with WEN for DEPTH-1.
      if (init_addr == AW'(DEPTH - 1)) init_done <= 1'b1;
    end else begin
      WEN <= xfer;
      if (xfer) begin
        WADDR  <= req_addr[gidx*AW +: AW];
        WDATA  <= req_data[gidx*WIDTH +: WIDTH];
        rr_ptr <= ptr_next;
      end
    end
  end

  dff_xchecker #(.WIDTH(WIDTH)) u_xchk (
    .clk  (CLK),
    .en   (WEN),
    .data (WDATA)
  );

endmodule

// File: tb/tb_dff_array_wr_sched.sv
// tb/tb_dff_array_wr_sched.sv - self-checking bench for dff_array_wr_sched
module tb_dff_array_wr_sched;

  localparam int N     = 4;
  localparam int DEPTH = 16;
  localparam int WIDTH = 32;
  localparam int AW    = 4;

  logic               CLK = 1'b0;
  logic               RST;
  logic [N-1:0]       req_valid;
  logic [N*AW-1:0]    req_addr;
  logic [N*WIDTH-1:0] req_data;
  logic [N-1:0]       req_ready;
  logic               wr_stall;
  logic               WEN;
  logic [AW-1:0]      WADDR;
  logic [WIDTH-1:0]   WDATA;
  logic               init_done;

  always #5 CLK = ~CLK;

  dff_array_wr_sched #(.NUM_REQ(N), .DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_stall  (wr_stall),
    .WEN       (WEN),
    .WADDR     (WADDR),
    .WDATA     (WDATA),
    .init_done (init_done)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [AW-1:0]    addr_s [N];
  logic [WIDTH-1:0] data_s [N];
  logic [N-1:0]     obs_ready;
  logic             obs_done;

  // Reference model: counts sweep writes and keeps a round-robin pointer as an integer.
  int               m_init;
  int               m_ptr;
  int               m_g;
  logic [N-1:0]     m_ready;
  logic             m_wen;
  logic [AW-1:0]    m_waddr;
  logic [WIDTH-1:0] m_wdata;
  logic             m_done;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_pick(input logic r, input logic [N-1:0] v, input logic st);
    m_g = -1;
    if (!r && m_init >= DEPTH && !st) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (m_g < 0 && v[idx]) m_g = idx;
      end
    end
    m_ready = (m_g >= 0) ? N'(1 << m_g) : '0;
  endtask

  task automatic model_step(input logic r);
    if (r) begin
      m_init = 0; m_ptr = 0; m_wen = 0; m_waddr = '0; m_wdata = '0; m_done = 0; m_g = -1;
    end else if (m_init < DEPTH) begin
      m_wen = 1; m_waddr = AW'(m_init); m_wdata = '0;
      m_init++;
      if (m_init == DEPTH) m_done = 1;
    end else if (m_g >= 0) begin
      m_wen = 1; m_waddr = addr_s[m_g]; m_wdata = data_s[m_g];
      m_ptr = (m_g + 1) % N;
    end else begin
      m_wen = 0;
    end
  endtask

  task automatic cycle(input logic r, input logic [N-1:0] v, input logic st);
    RST = r; req_valid = v; wr_stall = st;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]       = addr_s[i];
      req_data[i*WIDTH +: WIDTH] = data_s[i];
    end
    #1;
    model_pick(r, v, st);
    obs_ready = req_ready;
    obs_done  = init_done;
    chk("ready", 64'(req_ready), 64'(m_ready));
    @(posedge CLK);
    model_step(r);
    #1;
    chk("wen", 64'(WEN), 64'(m_wen));
    if (m_wen) begin
      chk("waddr", 64'(WADDR), 64'(m_waddr));
      chk("wdata", 64'(WDATA), 64'(m_wdata));
    end
    chk("init_done", 64'(init_done), 64'(m_done));
  endtask

  typedef struct {
    logic [N-1:0]     valid;
    logic             stall;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
    logic [N-1:0]     exp_ready;
    logic             exp_wen;
  } vec_t;

  vec_t tbl [17];

  initial begin
    int wen_cnt, done_at, g, lim;
    logic prev_done;
    logic [N-1:0] pv;

    // Rows 0-4: all valid; 5-9: only requester 2; 10: move pointer to 0; 11-16: stall then 1,3.
    tbl[0]  = '{4'b1111, 1'b0, 4'd0, 32'h100, 4'b0001, 1'b1};
    tbl[1]  = '{4'b1111, 1'b0, 4'd1, 32'h101, 4'b0010, 1'b1};
    tbl[2]  = '{4'b1111, 1'b0, 4'd2, 32'h102, 4'b0100, 1'b1};
    tbl[3]  = '{4'b1111, 1'b0, 4'd3, 32'h103, 4'b1000, 1'b1};
    tbl[4]  = '{4'b1111, 1'b0, 4'd4, 32'h104, 4'b0001, 1'b1};
    tbl[5]  = '{4'b0100, 1'b0, 4'd5, 32'hA0,  4'b0100, 1'b1};
    tbl[6]  = '{4'b0100, 1'b0, 4'd5, 32'hA1,  4'b0100, 1'b1};
    tbl[7]  = '{4'b0100, 1'b0, 4'd5, 32'hA2,  4'b0100, 1'b1};
    tbl[8]  = '{4'b0100, 1'b0, 4'd5, 32'hA3,  4'b0100, 1'b1};
    tbl[9]  = '{4'b0100, 1'b0, 4'd5, 32'hA4,  4'b0100, 1'b1};
    tbl[10] = '{4'b1000, 1'b0, 4'd9, 32'hB0,  4'b1000, 1'b1};
    tbl[11] = '{4'b1010, 1'b1, 4'd1, 32'hC0,  4'b0000, 1'b0};
    tbl[12] = '{4'b1010, 1'b1, 4'd1, 32'hC0,  4'b0000, 1'b0};
    tbl[13] = '{4'b1010, 1'b1, 4'd1, 32'hC0,  4'b0000, 1'b0};
    tbl[14] = '{4'b1010, 1'b0, 4'd1, 32'hC0,  4'b0010, 1'b1};
    tbl[15] = '{4'b1010, 1'b0, 4'd1, 32'hC1,  4'b1000, 1'b1};
    tbl[16] = '{4'b0000, 1'b0, 4'd1, 32'hC2,  4'b0000, 1'b0};

    for (int i = 0; i < N; i++) begin addr_s[i] = '0; data_s[i] = '0; end
    m_init = 0; m_ptr = 0; m_g = -1; m_wen = 0; m_waddr = '0; m_wdata = '0; m_done = 0;

    // Reset with every requester asserting: no grant, outputs cleared.
    cycle(1'b1, 4'b1111, 1'b0);
    cycle(1'b1, 4'b1111, 1'b0);
    chk("rst_ready", 64'(obs_ready), 64'h0);
    chk("rst_wen", 64'(WEN), 64'h0);
    chk("rst_done", 64'(init_done), 64'h0);

    // Idle sweep: exactly DEPTH writes, init_done rising on the last.
    wen_cnt = 0; done_at = 0;
    for (int c = 0; c < 20; c++) begin
      cycle(1'b0, '0, 1'b0);
      if (WEN) begin
        chk("sweep_addr", 64'(WADDR), 64'(wen_cnt));
        chk("sweep_data", 64'(WDATA), 64'h0);
        wen_cnt++;
      end
      if (init_done && done_at == 0) done_at = wen_cnt;
    end
    chk("sweep_wen_count", 64'(wen_cnt), 64'(DEPTH));
    chk("sweep_done_at", 64'(done_at), 64'(DEPTH));

    // Table-driven arbitration vectors.
    for (int r = 0; r < 17; r++) begin
      for (int i = 0; i < N; i++) begin
        addr_s[i] = tbl[r].addr ^ AW'(i ^ 2);
        data_s[i] = tbl[r].data ^ (WIDTH'(i ^ 2) << 24);
      end
      cycle(1'b0, tbl[r].valid, tbl[r].stall);
      chk("tbl_ready", 64'(obs_ready), 64'(tbl[r].exp_ready));
      chk("tbl_wen", 64'(WEN), 64'(tbl[r].exp_wen));
      if (tbl[r].exp_wen) begin
        g = 0;
        for (int i = 0; i < N; i++) if (tbl[r].exp_ready[i]) g = i;
        chk("tbl_waddr", 64'(WADDR), 64'(addr_s[g]));
        chk("tbl_wdata", 64'(WDATA), 64'(data_s[g]));
      end
      if (r == 9) chk("ptr_after_req2", 64'(dut.rr_ptr), 64'd3);
    end

    // Reset in the middle of the sweep at address 7.
    cycle(1'b1, '0, 1'b0);
    lim = 0;
    do begin cycle(1'b0, '0, 1'b0); lim++; end while (!(WEN && WADDR == AW'(7)) && lim < 30);
    chk("reach_addr7", 64'(lim < 30), 64'h1);
    cycle(1'b1, '0, 1'b0);
    chk("mid_init_rst_wen", 64'(WEN), 64'h0);
    cycle(1'b0, '0, 1'b0);
    chk("restart_addr", 64'(WADDR), 64'h0);
    lim = 0;
    do begin cycle(1'b0, '0, 1'b0); lim++; end while (!init_done && lim < 30);
    chk("reach_run", 64'(lim < 30), 64'h1);

    // Reset at a grant in RUN: the write is discarded and the pointer cleared.
    addr_s[2] = 4'd11; data_s[2] = 32'hDEAD_0002;
    cycle(1'b0, 4'b0100, 1'b0);
    cycle(1'b1, 4'b0100, 1'b0);
    chk("run_rst_ready", 64'(obs_ready), 64'h0);
    chk("run_rst_wen", 64'(WEN), 64'h0);
    chk("run_rst_ptr", 64'(dut.rr_ptr), 64'h0);

    // Requester 0 waits through the whole sweep; granted on the first RUN cycle.
    prev_done = 1'b0; lim = 0;
    addr_s[0] = 4'd6; data_s[0] = 32'h1234_5678;
    do begin
      prev_done = obs_done;
      cycle(1'b0, 4'b0001, 1'b0);
      lim++;
      if (lim == 1) chk("restart_addr2", 64'(WADDR), 64'h0);
    end while (obs_ready == '0 && lim < 40);
    chk("first_grant", 64'(obs_ready), 64'h1);
    chk("grant_with_done", 64'({prev_done, obs_done}), 64'b01);
    chk("first_run_waddr", 64'(WADDR), 64'd6);

    // Randomised traffic; requests hold their payload until transferred.
    pv = '0;
    for (int c = 0; c < 400; c++) begin
      logic r, st;
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(1, 0) == 1) begin
          pv[i] = 1'b1;
          addr_s[i] = AW'($urandom);
          data_s[i] = $urandom;
        end
      end
      r  = ($urandom_range(99, 0) == 0);
      st = ($urandom_range(3, 0) == 0);
      cycle(r, pv, st);
      if (m_ready != '0) begin
        for (int i = 0; i < N; i++) if (m_ready[i]) pv[i] = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
